// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage operand info, EX status and the hazard controller's stall/flush/forward outputs.
// master: pipeline side that drives ID/EX status; slave: the hazard controller.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rR1;
    logic [REG_AW-1:0] id_rR2;
    logic [1:0]        id_re;
    logic              id_rf_we;
    logic [REG_AW-1:0] id_wR;
    logic              id_is_load;
    logic              ex_busy;
    logic              ex_redirect;

    logic              hold_pc;
    logic              hold_ifid;
    logic              flush_ifid;
    logic              bubble_idex;
    logic              hold_idex;
    logic [1:0]        fwd_sel1;
    logic [1:0]        fwd_sel2;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_rR1, id_rR2, id_re, id_rf_we, id_wR, id_is_load,
        output ex_busy, ex_redirect,
        input  hold_pc, hold_ifid, flush_ifid, bubble_idex, hold_idex,
        input  fwd_sel1, fwd_sel2, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rR1, id_rR2, id_re, id_rf_we, id_wR, id_is_load,
        input  ex_busy, ex_redirect,
        output hold_pc, hold_ifid, flush_ifid, bubble_idex, hold_idex,
        output fwd_sel1, fwd_sel2, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage hazard controller: registered EX/MEM/WB writer scoreboard, combinational hold/flush/forward.
// Zero-latency outputs; ex_busy freezes EX and drains MEM, outranking redirect and data hazards.
module pipe_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 32
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    pipe_hazard_ctrl_if.slave hz
);
    localparam logic [1:0]       SEL_RF  = 2'd0;
    localparam logic [1:0]       SEL_EX  = 2'd1;
    localparam logic [1:0]       SEL_MEM = 2'd2;
    localparam logic [1:0]       SEL_WB  = 2'd3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic              v;
        logic              we;
        logic [REG_AW-1:0] wr;
        logic              ld;
    } sb_ent_t;

    sb_ent_t sb_ex;
    sb_ent_t sb_mem;
    sb_ent_t sb_wb;
    sb_ent_t ex_nxt;

    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    function automatic logic sb_match(input sb_ent_t e, input logic [REG_AW-1:0] r);
        return e.v && e.we && (e.wr == r) && (r != '0);
    endfunction

    // Returns {hazard, fwd_sel} for one source operand.
    function automatic logic [2:0] resolve(
        input logic              lv,
        input logic [REG_AW-1:0] r,
        input sb_ent_t           ex,
        input sb_ent_t           mem,
        input sb_ent_t           wb
    );
        logic       m_ex;
        logic       m_mem;
        logic       m_wb;
        logic       haz;
        logic [1:0] sel;
        m_ex  = sb_match(ex, r);
        m_mem = sb_match(mem, r);
        m_wb  = sb_match(wb, r);
        haz   = 1'b0;
        sel   = SEL_RF;
        if (lv) begin
            if (FWD_EN) begin
                if (m_ex)       sel = SEL_EX;
                else if (m_mem) sel = SEL_MEM;
                else if (m_wb)  sel = SEL_WB;
                // Load data only exists from MEM onwards, so an EX load cannot be forwarded yet.
                haz = m_ex && ex.ld;
            end else begin
                haz = m_ex || m_mem;
                if (m_wb) sel = SEL_WB;
            end
        end
        return {haz, sel};
    endfunction

    logic [2:0] res1;
    logic [2:0] res2;
    logic       hazard;

    assign res1   = resolve(hz.id_valid & hz.id_re[0], hz.id_rR1, sb_ex, sb_mem, sb_wb);
    assign res2   = resolve(hz.id_valid & hz.id_re[1], hz.id_rR2, sb_ex, sb_mem, sb_wb);
    assign hazard = res1[2] | res2[2];

    logic hold_pc;
    logic hold_ifid;
    logic flush_ifid;
    logic bubble_idex;
    logic hold_idex;

    always_comb begin
        hold_pc     = 1'b0;
        hold_ifid   = 1'b0;
        flush_ifid  = 1'b0;
        bubble_idex = 1'b0;
        hold_idex   = 1'b0;
        if (hz.ex_busy) begin
            hold_pc   = 1'b1;
            hold_ifid = 1'b1;
            hold_idex = 1'b1;
        end else if (hz.ex_redirect) begin
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
        end else if (hazard) begin
            hold_pc     = 1'b1;
            hold_ifid   = 1'b1;
            bubble_idex = 1'b1;
        end
    end

    always_comb begin
        ex_nxt = '0;
        if (!(bubble_idex || hz.ex_redirect || !hz.id_valid)) begin
            ex_nxt = {1'b1, hz.id_rf_we, hz.id_wR, hz.id_is_load};
        end
    end

    logic stall_inc;
    logic flush_inc;

    assign stall_inc = hazard && !hz.ex_busy && !hz.ex_redirect;
    assign flush_inc = hz.ex_redirect && !hz.ex_busy;

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst) begin
            sb_ex     <= '0;
            sb_mem    <= '0;
            sb_wb     <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            sb_wb <= sb_mem;
            // A busy EX keeps its instruction and sends bubbles down to MEM.
            if (hz.ex_busy) begin
                sb_mem <= '0;
            end else begin
                sb_mem <= sb_ex;
                sb_ex  <= ex_nxt;
            end
            if (stall_inc && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign hz.hold_pc     = hold_pc;
    assign hz.hold_ifid   = hold_ifid;
    assign hz.flush_ifid  = flush_ifid;
    assign hz.bubble_idex = bubble_idex;
    assign hz.hold_idex   = hold_idex;
    assign hz.fwd_sel1    = res1[1:0];
    assign hz.fwd_sel2    = res2[1:0];
    assign hz.stall_cnt   = stall_cnt;
    assign hz.flush_cnt   = flush_cnt;

    a_idex_exclusive: assert property (@(posedge cpu_clk) disable iff (!cpu_rst)
        !(hold_idex && bubble_idex));
    a_ifid_exclusive: assert property (@(posedge cpu_clk) disable iff (!cpu_rst)
        !(hold_ifid && flush_ifid));
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
    localparam int AW = 5;
    localparam int CW = 4;

    typedef logic [8+2*CW:0] ovec_t;

    logic cpu_clk = 1'b0;
    logic cpu_rst = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    pipe_hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) ifa ();
    pipe_hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) ifb ();

    pipe_hazard_ctrl #(.REG_AW(AW), .FWD_EN(1'b1), .CNT_W(CW)) u_fwd (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .hz(ifa));
    pipe_hazard_ctrl #(.REG_AW(AW), .FWD_EN(1'b0), .CNT_W(CW)) u_stall (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .hz(ifb));

    ovec_t exp_q[$];
    int    dut_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic ovec_t ev(bit hpc, bit hif, bit fif, bit bub, bit hid,
                                 logic [1:0] f1, logic [1:0] f2, int sc, int fc);
        logic [CW-1:0] s;
        logic [CW-1:0] f;
        s = sc[CW-1:0];
        f = fc[CW-1:0];
        return {hpc, hif, fif, bub, hid, f1, f2, s, f};
    endfunction

    function automatic ovec_t dut_out(int d);
        if (d == 0)
            return {ifa.hold_pc, ifa.hold_ifid, ifa.flush_ifid, ifa.bubble_idex, ifa.hold_idex,
                    ifa.fwd_sel1, ifa.fwd_sel2, ifa.stall_cnt, ifa.flush_cnt};
        return {ifb.hold_pc, ifb.hold_ifid, ifb.flush_ifid, ifb.bubble_idex, ifb.hold_idex,
                ifb.fwd_sel1, ifb.fwd_sel2, ifb.stall_cnt, ifb.flush_cnt};
    endfunction

    task automatic expect_out(int d, string nm, ovec_t e);
        exp_q.push_back(e);
        dut_q.push_back(d);
        name_q.push_back(nm);
    endtask

    // Monitor: every expectation pushed this cycle is compared mid-cycle.
    always @(negedge cpu_clk) begin
        while (exp_q.size() > 0) begin
            ovec_t e;
            ovec_t a;
            int    d;
            string nm;
            e  = exp_q.pop_front();
            d  = dut_q.pop_front();
            nm = name_q.pop_front();
            a  = dut_out(d);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: dut%0d outputs {hpc,hif,fif,bub,hid,f1,f2,stall,flush} got %b expected %b",
                         nm, d, a, e);
            end
        end
    end

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic set_id(int d, logic v, logic [AW-1:0] r1, logic [AW-1:0] r2, logic [1:0] re,
                          logic we, logic [AW-1:0] wr, logic ld);
        if (d == 0) begin
            ifa.id_valid = v; ifa.id_rR1 = r1; ifa.id_rR2 = r2; ifa.id_re = re;
            ifa.id_rf_we = we; ifa.id_wR = wr; ifa.id_is_load = ld;
        end else begin
            ifb.id_valid = v; ifb.id_rR1 = r1; ifb.id_rR2 = r2; ifb.id_re = re;
            ifb.id_rf_we = we; ifb.id_wR = wr; ifb.id_is_load = ld;
        end
    endtask

    task automatic set_ctl(int d, logic busy, logic redir);
        if (d == 0) begin
            ifa.ex_busy = busy; ifa.ex_redirect = redir;
        end else begin
            ifb.ex_busy = busy; ifb.ex_redirect = redir;
        end
    endtask

    task automatic idle(int d);
        set_id(d, 1'b0, '0, '0, 2'b00, 1'b0, '0, 1'b0);
        set_ctl(d, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(0);
        idle(1);
        cpu_rst = 1'b0;
        tick();
        expect_out(0, "rst_a", ev(0,0,0,0,0,0,0,0,0));
        expect_out(1, "rst_b", ev(0,0,0,0,0,0,0,0,0));
        tick();
        cpu_rst = 1'b1;

        // FWD_EN=1: ALU forwarding from EX, MEM and WB
        set_id(0, 1, 0, 0, 2'b00, 1, 5, 0);
        expect_out(0, "a_add_issue", ev(0,0,0,0,0,0,0,0,0)); tick();
        set_id(0, 1, 5, 0, 2'b01, 1, 8, 0);
        expect_out(0, "a_fwd_ex", ev(0,0,0,0,0,1,0,0,0)); tick();
        set_id(0, 1, 8, 5, 2'b11, 0, 0, 0);
        expect_out(0, "a_fwd_ex_mem", ev(0,0,0,0,0,1,2,0,0)); tick();
        set_id(0, 1, 5, 8, 2'b11, 0, 0, 0);
        expect_out(0, "a_fwd_wb_mem", ev(0,0,0,0,0,3,2,0,0)); tick();
        set_id(0, 1, 0, 8, 2'b01, 0, 0, 0);
        expect_out(0, "a_x0_nonlive", ev(0,0,0,0,0,0,0,0,0)); tick();

        // load-use: one stall cycle then MEM forward
        set_id(0, 1, 0, 0, 2'b00, 1, 6, 1);
        expect_out(0, "a_lw_issue", ev(0,0,0,0,0,0,0,0,0)); tick();
        set_id(0, 1, 1, 6, 2'b11, 1, 9, 0);
        expect_out(0, "a_load_use", ev(1,1,0,1,0,0,1,0,0)); tick();
        expect_out(0, "a_load_fwd", ev(0,0,0,0,0,0,2,1,0)); tick();

        // redirect outranks a pending load-use
        set_id(0, 1, 0, 0, 2'b00, 1, 10, 1);
        expect_out(0, "a_lw10_issue", ev(0,0,0,0,0,0,0,1,0)); tick();
        set_id(0, 1, 10, 0, 2'b01, 0, 0, 0);
        set_ctl(0, 0, 1);
        expect_out(0, "a_redirect", ev(0,0,1,1,0,1,0,1,0)); tick();
        set_ctl(0, 0, 0);
        set_id(0, 1, 0, 0, 2'b00, 1, 13, 0);
        expect_out(0, "a_after_redirect", ev(0,0,0,0,0,0,0,1,1)); tick();
        set_id(0, 1, 0, 0, 2'b00, 1, 11, 1);
        expect_out(0, "a_lw11_issue", ev(0,0,0,0,0,0,0,1,1)); tick();

        // ex_busy for 4 cycles with redirect and hazard present: only holds, MEM drains
        set_ctl(0, 1, 1);
        set_id(0, 1, 11, 13, 2'b11, 1, 12, 0);
        expect_out(0, "a_busy1", ev(1,1,0,0,1,1,2,1,1)); tick();
        expect_out(0, "a_busy2", ev(1,1,0,0,1,1,3,1,1)); tick();
        expect_out(0, "a_busy3", ev(1,1,0,0,1,1,0,1,1)); tick();
        expect_out(0, "a_busy4", ev(1,1,0,0,1,1,0,1,1)); tick();
        set_ctl(0, 0, 0);
        expect_out(0, "a_busy_release", ev(1,1,0,1,0,1,0,1,1)); tick();
        expect_out(0, "a_busy_fwd", ev(0,0,0,0,0,2,0,2,1)); tick();

        // x0 is never a hazard, then a one-cycle reset
        set_id(0, 1, 0, 0, 2'b00, 1, 0, 0);
        expect_out(0, "a_x0_writer", ev(0,0,0,0,0,0,0,2,1)); tick();
        set_id(0, 1, 0, 0, 2'b11, 0, 0, 0);
        expect_out(0, "a_x0_read", ev(0,0,0,0,0,0,0,2,1)); tick();
        cpu_rst = 1'b0;
        set_id(0, 1, 12, 0, 2'b01, 0, 0, 0);
        tick();
        cpu_rst = 1'b1;
        expect_out(0, "a_post_reset", ev(0,0,0,0,0,0,0,0,0));
        expect_out(1, "b_post_reset", ev(0,0,0,0,0,0,0,0,0)); tick();

        // back-to-back dependent loads: alternating stall/forward until stall_cnt saturates
        set_id(0, 1, 20, 0, 2'b01, 1, 20, 1);
        for (int i = 0; i < 40; i++) begin
            int sc;
            sc = (i / 2 > 15) ? 15 : i / 2;
            if (i == 0)
                expect_out(0, "a_sat_first", ev(0,0,0,0,0,0,0,0,0));
            else if (i % 2 == 1)
                expect_out(0, "a_sat_stall", ev(1,1,0,1,0,1,0,sc,0));
            else
                expect_out(0, "a_sat_fwd", ev(0,0,0,0,0,2,0,sc,0));
            tick();
        end
        idle(0);

        // FWD_EN=0: stall through EX and MEM, forward only from WB
        set_id(1, 1, 0, 0, 2'b00, 1, 7, 0);
        expect_out(1, "b_add_issue", ev(0,0,0,0,0,0,0,0,0)); tick();
        set_id(1, 1, 7, 0, 2'b01, 1, 14, 0);
        expect_out(1, "b_ex_stall", ev(1,1,0,1,0,0,0,0,0)); tick();
        expect_out(1, "b_mem_stall", ev(1,1,0,1,0,0,0,1,0)); tick();
        expect_out(1, "b_wb_fwd", ev(0,0,0,0,0,3,0,2,0)); tick();
        set_id(1, 1, 7, 14, 2'b10, 0, 0, 0);
        expect_out(1, "b_ex_stall_r2", ev(1,1,0,1,0,0,0,2,0)); tick();
        expect_out(1, "b_mem_stall_r2", ev(1,1,0,1,0,0,0,3,0)); tick();
        expect_out(1, "b_wb_fwd_r2", ev(0,0,0,0,0,0,3,4,0)); tick();
        idle(1);
        set_ctl(1, 0, 1);
        expect_out(1, "b_redirect", ev(0,0,1,1,0,0,0,4,0)); tick();
        set_ctl(1, 1, 0);
        expect_out(1, "b_busy", ev(1,1,0,0,1,0,0,4,1)); tick();
        set_ctl(1, 0, 0);
        expect_out(1, "b_idle", ev(0,0,0,0,0,0,0,4,1)); tick();
        tick();

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
